// File: rtl/bilinear_core_simd.sv
// SIMD bilinear downscaler core: LANES output pixels of one row per advance,
// three-stage pipeline (issue/BRAM read, weight+accumulate, registered write).
module bilinear_core_simd #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned DIM_W  = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DIM_W-1:0]            in_w,
    input  logic [DIM_W-1:0]            in_h,
    input  logic [DIM_W-1:0]            out_w,
    input  logic [DIM_W-1:0]            out_h,
    input  logic [15:0]                 inv_scale_q,
    input  logic                        step_mode,
    input  logic                        step,
    output logic                        step_ack,
    output logic                        busy,
    output logic                        done,
    output logic [LANES*4*ADDR_W-1:0]   rd_addr,
    input  logic [LANES*4*PIX_W-1:0]    rd_data,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [LANES*PIX_W-1:0]      wr_data,
    output logic [LANES-1:0]            wr_mask
);

    localparam int unsigned ACC_W = PIX_W + 2*FRAC + 2;
    localparam int unsigned GRP_W = 4*ADDR_W;
    localparam int          HALF  = 1 << (FRAC-1);
    localparam int          ONE   = 1 << FRAC;
    localparam logic [ACC_W-1:0] RND  = ACC_W'(1) << (2*FRAC-1);
    localparam logic [ACC_W-1:0] PMAX = ACC_W'((1 << PIX_W) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                    state;
    logic [DIM_W-1:0]          x, y;
    logic                      adv, adv_q;
    logic                      last_col, last_row;

    logic [LANES*4*ADDR_W-1:0] iss_addr;
    logic [LANES*FRAC-1:0]     iss_tx;
    logic [FRAC-1:0]           iss_ty;
    logic [LANES-1:0]          iss_mask;
    logic [ADDR_W-1:0]         iss_waddr;

    logic                      s1_valid, s2_valid;
    logic [LANES*FRAC-1:0]     s1_tx, s2_tx;
    logic [FRAC-1:0]           s1_ty, s2_ty;
    logic [LANES-1:0]          s1_mask, s2_mask;
    logic [ADDR_W-1:0]         s1_waddr, s2_waddr;

    logic [LANES*4*PIX_W-1:0]  pix_src, pix_hold;
    logic [LANES*PIX_W-1:0]    s2_pix;

    // Source coordinate in FRAC fixed point for output coordinate o.
    function automatic logic signed [31:0] src_coord(input logic signed [31:0] o,
                                                     input logic [15:0] inv);
        logic signed [31:0] t;
        t = ((o <<< FRAC) + HALF) * $signed({16'd0, inv});
        return (t >>> FRAC) - HALF;
    endfunction

    function automatic logic signed [31:0] clamp_lo(input logic signed [31:0] c,
                                                    input logic [DIM_W-1:0] dim);
        logic signed [31:0] v, mx;
        v  = c >>> FRAC;
        mx = $signed(32'(dim)) - 1;
        if (v > mx) v = mx;
        if (v < 0)  v = 0;
        return v;
    endfunction

    function automatic logic signed [31:0] clamp_hi(input logic signed [31:0] lo,
                                                    input logic [DIM_W-1:0] dim);
        logic signed [31:0] mx;
        mx = $signed(32'(dim)) - 1;
        return (lo + 1 > mx) ? lo : lo + 1;
    endfunction

    function automatic logic [ADDR_W-1:0] lin_addr(input logic signed [31:0] r,
                                                   input logic signed [31:0] c,
                                                   input logic [DIM_W-1:0] w);
        return ADDR_W'(r) * ADDR_W'(w) + ADDR_W'(c);
    endfunction

    assign adv       = (!step_mode || (step && !step_ack)) && (!wr_valid || wr_ready);
    assign last_col  = (32'(x) + LANES) >= 32'(out_w);
    assign last_row  = (y == out_h - DIM_W'(1));
    assign iss_waddr = ADDR_W'(y) * ADDR_W'(out_w) + ADDR_W'(x);

    // Issue stage: per-lane neighbour addresses and fractions for group (x, y).
    always_comb begin
        logic signed [31:0] ys, y0, y1, xs, x0, x1, xo;
        logic [GRP_W-1:0]   g0;
        iss_addr = '0;
        iss_tx   = '0;
        iss_mask = '0;
        g0       = '0;
        ys = src_coord($signed(32'(y)), inv_scale_q);
        y0 = clamp_lo(ys, in_h);
        y1 = clamp_hi(y0, in_h);
        iss_ty = ys[FRAC-1:0];
        for (int l = 0; l < LANES; l++) begin
            xo = $signed(32'(x)) + l;
            xs = src_coord(xo, inv_scale_q);
            x0 = clamp_lo(xs, in_w);
            x1 = clamp_hi(x0, in_w);
            iss_mask[l] = (xo < $signed(32'(out_w)));
            if (iss_mask[l]) begin
                iss_tx[l*FRAC +: FRAC]     = xs[FRAC-1:0];
                iss_addr[l*GRP_W +: GRP_W] = {lin_addr(y1, x1, in_w), lin_addr(y1, x0, in_w),
                                              lin_addr(y0, x1, in_w), lin_addr(y0, x0, in_w)};
            end else begin
                iss_addr[l*GRP_W +: GRP_W] = g0;
            end
            if (l == 0) g0 = iss_addr[GRP_W-1:0];
        end
    end

    // BRAM data is fresh only the cycle after an advance; during a stall the
    // BRAM already shows the next group, so S2 uses the copy captured earlier.
    assign pix_src = adv_q ? rd_data : pix_hold;

    // S2: bilinear weights, accumulate, round and saturate per lane.
    always_comb begin
        logic [ACC_W-1:0] tx, ty, ntx, nty, acc, q;
        s2_pix = '0;
        ty  = ACC_W'(s2_ty);
        nty = ACC_W'(ONE) - ty;
        for (int l = 0; l < LANES; l++) begin
            tx  = ACC_W'(s2_tx[l*FRAC +: FRAC]);
            ntx = ACC_W'(ONE) - tx;
            acc = ACC_W'(pix_src[(4*l+0)*PIX_W +: PIX_W]) * ntx * nty
                + ACC_W'(pix_src[(4*l+1)*PIX_W +: PIX_W]) * tx  * nty
                + ACC_W'(pix_src[(4*l+2)*PIX_W +: PIX_W]) * ntx * ty
                + ACC_W'(pix_src[(4*l+3)*PIX_W +: PIX_W]) * tx  * ty;
            q = (acc + RND) >> (2*FRAC);
            if (s2_mask[l])
                s2_pix[l*PIX_W +: PIX_W] = (q > PMAX) ? PMAX[PIX_W-1:0] : q[PIX_W-1:0];
        end
    end

    // Control FSM, group walker and step handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_ack <= 1'b0;
            x        <= '0;
            y        <= '0;
        end else begin
            if (!step_mode)
                step_ack <= 1'b0;
            else if (step && !step_ack && (!wr_valid || wr_ready))
                step_ack <= 1'b1;
            else if (!step && step_ack)
                step_ack <= 1'b0;

            unique case (state)
                IDLE: if (start) begin
                    done  <= 1'b0;
                    busy  <= 1'b1;
                    x     <= '0;
                    y     <= '0;
                    state <= (out_w == '0 || out_h == '0) ? FIN : RUN;
                end
                RUN: if (adv) begin
                    if (last_col) begin
                        x <= '0;
                        y <= y + DIM_W'(1);
                        if (last_row) state <= DRAIN;
                    end else begin
                        x <= x + DIM_W'(LANES);
                    end
                end
                DRAIN: if (!s1_valid && !s2_valid) state <= FIN;
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pipeline registers; the output stage also retires a group accepted while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adv_q    <= 1'b0;
            pix_hold <= '0;
            rd_addr  <= '0;
            s1_valid <= 1'b0;
            s1_tx    <= '0;
            s1_ty    <= '0;
            s1_mask  <= '0;
            s1_waddr <= '0;
            s2_valid <= 1'b0;
            s2_tx    <= '0;
            s2_ty    <= '0;
            s2_mask  <= '0;
            s2_waddr <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_mask  <= '0;
        end else begin
            adv_q    <= adv;
            pix_hold <= pix_src;
            if (adv) begin
                s1_valid <= (state == RUN);
                if (state == RUN) begin
                    rd_addr  <= iss_addr;
                    s1_tx    <= iss_tx;
                    s1_ty    <= iss_ty;
                    s1_mask  <= iss_mask;
                    s1_waddr <= iss_waddr;
                end
                s2_valid <= s1_valid;
                s2_tx    <= s1_tx;
                s2_ty    <= s1_ty;
                s2_mask  <= s1_mask;
                s2_waddr <= s1_waddr;
                wr_valid <= s2_valid;
                if (s2_valid) begin
                    wr_addr <= s2_waddr;
                    wr_data <= s2_pix;
                    wr_mask <= s2_mask;
                end
            end else if (wr_ready) begin
                wr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bilinear_core_simd.sv
// Scoreboard bench for bilinear_core_simd: identity, 2x down, tail lanes,
// backpressure, stepping, reset abort and zero-size runs.
module tb_bilinear_core_simd;

    localparam int LANES  = 4;
    localparam int PIX_W  = 8;
    localparam int DIM_W  = 16;
    localparam int ADDR_W = 32;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic [DIM_W-1:0]            in_w, in_h, out_w, out_h;
    logic [15:0]                 inv_scale_q;
    logic                        step_mode, step, step_ack, busy, done;
    logic [LANES*4*ADDR_W-1:0]   rd_addr;
    logic [LANES*4*PIX_W-1:0]    rd_data;
    logic                        wr_valid, wr_ready;
    logic [ADDR_W-1:0]           wr_addr;
    logic [LANES*PIX_W-1:0]      wr_data;
    logic [LANES-1:0]            wr_mask;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_wr = 0;
    logic [7:0] mem [0:1023];

    bilinear_core_simd dut (
        .clk(clk), .rst(rst), .start(start),
        .in_w(in_w), .in_h(in_h), .out_w(out_w), .out_h(out_h),
        .inv_scale_q(inv_scale_q), .step_mode(step_mode), .step(step),
        .step_ack(step_ack), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM model, one read port per lane/neighbour.
    always @(posedge clk)
        for (int i = 0; i < LANES*4; i++)
            rd_data[i*PIX_W +: PIX_W] <= mem[rd_addr[i*ADDR_W +: 10]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    // Output monitor: pops the scoreboard on each transfer, checks stall stability.
    logic stalled = 1'b0;
    exp_t held;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 64'(wr_valid), 64'd1);
                check("stall_addr", 64'(wr_addr), 64'(held.addr));
                check("stall_data", 64'(wr_data), 64'(held.data));
                check("stall_mask", 64'(wr_mask), 64'(held.mask));
            end
            if (wr_valid && wr_ready) begin
                n_wr++;
                stalled = 1'b0;
                if (sb.size() == 0) begin
                    check("extra_wr", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", 64'(wr_data), 64'(e.data));
                    check("wr_mask", 64'(wr_mask), 64'(e.mask));
                end
            end else if (wr_valid) begin
                stalled = 1'b1;
                held    = {wr_addr, wr_data, wr_mask};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic push(input int addr, input logic [31:0] data, input int mask);
        exp_t e;
        e.addr = 32'(addr);
        e.data = data;
        e.mask = 4'(mask);
        sb.push_back(e);
    endtask

    // pat 0: 16y+x, 1: 16x, 2: 16y
    task automatic load_img(input int w, input int h, input int pat);
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                mem[yy*w + xx] = (pat == 0) ? 8'(16*yy + xx) : (pat == 1) ? 8'(16*xx) : 8'(16*yy);
    endtask

    task automatic cfg(input int iw, input int ih, input int ow, input int oh, input int inv);
        in_w = 16'(iw); in_h = 16'(ih); out_w = 16'(ow); out_h = 16'(oh);
        inv_scale_q = 16'(inv);
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_done_clr", 64'(done), 64'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c = 0;
        while (!done && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic do_step(input int hold);
        int c = 0;
        step = 1'b1;
        do begin
            tick();
            c++;
        end while (!step_ack && c < 10);
        repeat (hold) tick();
        check("step_ack_hi", 64'(step_ack), 64'd1);
        step = 1'b0;
        tick();
        check("step_ack_lo", 64'(step_ack), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_ack"}, 64'(step_ack), 64'd0);
        check({tag, "_wr_valid"}, 64'(wr_valid), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        check({tag, "_wr_mask"}, 64'(wr_mask), 64'd0);
        check({tag, "_rd_lo"}, rd_addr[63:0], 64'd0);
        check({tag, "_rd_hi"}, rd_addr[127:64], 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

    initial begin
        int base, c;
        rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; wr_ready = 1'b1;
        cfg(0, 0, 0, 0, 0);
        load_img(0, 0, 0);
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // T1 identity 4x4
        load_img(4, 4, 0);
        for (int yy = 0; yy < 4; yy++)
            push(4*yy, pack4(16*yy, 16*yy+1, 16*yy+2, 16*yy+3), 4'hF);
        base = n_wr;
        cfg(4, 4, 4, 4, 'h100);
        kick();
        wait_done("t1", 200);
        check("t1_nwr", 64'(n_wr - base), 64'd4);
        repeat (3) tick();
        check("t1_done_sticky", 64'(done), 64'd1);

        // T2 2x down, horizontal ramp
        load_img(8, 8, 1);
        for (int yy = 0; yy < 4; yy++) push(4*yy, pack4(8, 40, 72, 104), 4'hF);
        base = n_wr;
        cfg(8, 8, 4, 4, 'h200);
        kick();
        wait_done("t2", 200);
        check("t2_nwr", 64'(n_wr - base), 64'd4);

        // T2b 2x down, vertical ramp
        load_img(8, 8, 2);
        for (int yy = 0; yy < 4; yy++) push(4*yy, pack4(32*yy+8, 32*yy+8, 32*yy+8, 32*yy+8), 4'hF);
        kick();
        wait_done("t2b", 200);

        // T3 tail lanes, out 5x2
        load_img(8, 4, 0);
        push(0, pack4(0, 1, 2, 3), 4'hF);
        push(4, pack4(4, 0, 0, 0), 4'h1);
        push(5, pack4(16, 17, 18, 19), 4'hF);
        push(9, pack4(20, 0, 0, 0), 4'h1);
        base = n_wr;
        cfg(8, 4, 5, 2, 'h100);
        kick();
        wait_done("t3", 200);
        check("t3_nwr", 64'(n_wr - base), 64'd4);

        // T4 backpressure mid-run
        load_img(8, 8, 1);
        for (int yy = 0; yy < 4; yy++) push(4*yy, pack4(8, 40, 72, 104), 4'hF);
        base = n_wr;
        cfg(8, 8, 4, 4, 'h200);
        kick();
        c = 0;
        while (n_wr < base + 1 && c < 100) begin tick(); c++; end
        check("t4_first_wr", 64'(n_wr - base), 64'd1);
        wr_ready = 1'b0;
        repeat (3) tick();
        wr_ready = 1'b1;
        wait_done("t4", 200);
        check("t4_nwr", 64'(n_wr - base), 64'd4);

        // T5 stepping with T1 setup
        load_img(4, 4, 0);
        for (int yy = 0; yy < 4; yy++)
            push(4*yy, pack4(16*yy, 16*yy+1, 16*yy+2, 16*yy+3), 4'hF);
        base = n_wr;
        cfg(4, 4, 4, 4, 'h100);
        step_mode = 1'b1;
        kick();
        repeat (4) tick();
        check("t5_no_adv_wo_step", 64'(n_wr - base), 64'd0);
        do_step(4);
        check("t5_wr_after_1", 64'(n_wr - base), 64'd0);
        for (int k = 2; k <= 6; k++) begin
            do_step(0);
            check("t5_wr_after_k", 64'(n_wr - base), 64'((k > 2) ? k - 2 : 0));
        end
        wait_done("t5", 50);
        check("t5_nwr", 64'(n_wr - base), 64'd4);
        step_mode = 1'b0;
        tick();

        // T6 reset mid-run, then zero-size start
        load_img(8, 8, 1);
        for (int yy = 0; yy < 4; yy++) push(4*yy, pack4(8, 40, 72, 104), 4'hF);
        base = n_wr;
        cfg(8, 8, 4, 4, 'h200);
        kick();
        c = 0;
        while (n_wr < base + 2 && c < 100) begin tick(); c++; end
        check("t6_two_wr", 64'(n_wr - base), 64'd2);
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_rst");
        sb.delete();
        repeat (2) tick();
        rst = 1'b0;
        base = n_wr;
        repeat (30) tick();
        check("t6_no_wr_after_rst", 64'(n_wr - base), 64'd0);
        check("t6_done_low", 64'(done), 64'd0);
        cfg(8, 8, 4, 0, 'h200);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t6_zero_done", 64'(done), 64'd1);
        repeat (5) tick();
        check("t6_zero_no_wr", 64'(n_wr - base), 64'd0);
        check("t6_zero_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
